// File: rtl/sys_ctrl_gen2.sv
// rtl/sys_ctrl_gen2.sv - command-frame system controller; optional write-ack to FIFO under WR_ACK_EN
module sys_ctrl_gen2 #(
  parameter int DATA_WIDTH     = 8,
  parameter int ADDR_WIDTH     = 4,
  parameter int ALU_OUT_WIDTH  = 16,
  parameter int FUN_WIDTH      = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic [DATA_WIDTH-1:0]    DATA_IN,
  input  logic                     DATA_IN_VALID,
  input  logic [DATA_WIDTH-1:0]    Rd_D,
  input  logic                     Rd_D_Valid,
  input  logic [ALU_OUT_WIDTH-1:0] ALU_OUT,
  input  logic                     ALU_OUT_Valid,
  input  logic                     F_FULL,
  output logic                     WrEn,
  output logic                     RdEn,
  output logic [ADDR_WIDTH-1:0]    Addr,
  output logic [DATA_WIDTH-1:0]    Wr_D,
  output logic [FUN_WIDTH-1:0]     FUN,
  output logic                     ALU_EN,
  output logic                     GATE_EN,
  output logic                     W_INC,
  output logic [DATA_WIDTH-1:0]    Wr_DATA,
  output logic                     CMD_ERR
);
  localparam int NBYTES = ALU_OUT_WIDTH / DATA_WIDTH;
  localparam int CW     = $clog2(NBYTES + 1);
  localparam int TW     = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [3:0] {
    IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT, OPA, OPB, ALU_FUN, ALU_WAIT, TX_SEND
  } state_t;

  state_t                   state, state_nx;
  logic [ALU_OUT_WIDTH-1:0] tx_buf, tx_buf_nx;
  logic [CW-1:0]            tx_cnt, tx_cnt_nx;
  logic [TW-1:0]            timer, timer_nx;
  logic                     wr_en_nx, rd_en_nx, alu_en_nx, gate_en_nx, w_inc_nx, cmd_err_nx;
  logic [ADDR_WIDTH-1:0]    addr_nx;
  logic [DATA_WIDTH-1:0]    wr_d_nx, wr_data_nx;
  logic [FUN_WIDTH-1:0]     fun_nx;
  logic [7:0]               cmd;
  logic                     timed, expire, known_cmd;

  // Only the low byte of the first frame carries the command code.
  assign cmd       = DATA_IN[7:0];
  assign known_cmd = cmd inside {8'hAA, 8'hBB, 8'hCC, 8'hDD};
  // Transmission is never abandoned, so only command/wait states are timed.
  assign timed     = (state != IDLE) && (state != TX_SEND);
  assign expire    = timed && (timer == TW'(TIMEOUT_CYCLES - 1));

  // State register plus all registered outputs and the TX byte buffer.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      state   <= IDLE;
      tx_buf  <= '0;
      tx_cnt  <= '0;
      timer   <= '0;
      WrEn    <= 1'b0;
      RdEn    <= 1'b0;
      Addr    <= '0;
      Wr_D    <= '0;
      FUN     <= '0;
      ALU_EN  <= 1'b0;
      GATE_EN <= 1'b0;
      W_INC   <= 1'b0;
      Wr_DATA <= '0;
      CMD_ERR <= 1'b0;
    end else begin
      state   <= state_nx;
      tx_buf  <= tx_buf_nx;
      tx_cnt  <= tx_cnt_nx;
      timer   <= timer_nx;
      WrEn    <= wr_en_nx;
      RdEn    <= rd_en_nx;
      Addr    <= addr_nx;
      Wr_D    <= wr_d_nx;
      FUN     <= fun_nx;
      ALU_EN  <= alu_en_nx;
      GATE_EN <= gate_en_nx;
      W_INC   <= w_inc_nx;
      Wr_DATA <= wr_data_nx;
      CMD_ERR <= cmd_err_nx;
    end
  end

  // Next-state decode; timeout overrides any frame or response arriving the same cycle.
  always_comb begin
    state_nx = state;
    if (expire) begin
      state_nx = IDLE;
    end else begin
      case (state)
        IDLE: if (DATA_IN_VALID) begin
          case (cmd)
            8'hAA:   state_nx = WR_ADDR;
            8'hBB:   state_nx = RD_ADDR;
            8'hCC:   state_nx = OPA;
            8'hDD:   state_nx = ALU_FUN;
            default: state_nx = IDLE;
          endcase
        end
`ifdef WR_ACK_EN
        WR_DATA:  if (DATA_IN_VALID) state_nx = TX_SEND;
`else
        WR_DATA:  if (DATA_IN_VALID) state_nx = IDLE;
`endif
        WR_ADDR:  if (DATA_IN_VALID) state_nx = WR_DATA;
        RD_ADDR:  if (DATA_IN_VALID) state_nx = RD_WAIT;
        RD_WAIT:  if (Rd_D_Valid)    state_nx = TX_SEND;
        OPA:      if (DATA_IN_VALID) state_nx = OPB;
        OPB:      if (DATA_IN_VALID) state_nx = ALU_FUN;
        ALU_FUN:  if (DATA_IN_VALID) state_nx = ALU_WAIT;
        ALU_WAIT: if (ALU_OUT_Valid) state_nx = TX_SEND;
        TX_SEND:  if (!F_FULL && tx_cnt <= CW'(1)) state_nx = IDLE;
        default:  state_nx = IDLE;
      endcase
    end
  end

  // Next values for registered outputs, TX buffer and timeout counter.
  always_comb begin
    wr_en_nx   = 1'b0;
    rd_en_nx   = 1'b0;
    alu_en_nx  = 1'b0;
    w_inc_nx   = 1'b0;
    cmd_err_nx = 1'b0;
    gate_en_nx = GATE_EN;
    addr_nx    = Addr;
    wr_d_nx    = Wr_D;
    fun_nx     = FUN;
    wr_data_nx = Wr_DATA;
    tx_buf_nx  = tx_buf;
    tx_cnt_nx  = tx_cnt;
    timer_nx   = timed ? timer + 1'b1 : '0;
    if (expire) begin
      cmd_err_nx = 1'b1;
      gate_en_nx = 1'b0;
      timer_nx   = '0;
    end else begin
      case (state)
        IDLE: if (DATA_IN_VALID && !known_cmd) cmd_err_nx = 1'b1;
        WR_ADDR: if (DATA_IN_VALID) begin
          addr_nx  = DATA_IN[ADDR_WIDTH-1:0];
          timer_nx = '0;
        end
        WR_DATA: if (DATA_IN_VALID) begin
          wr_d_nx  = DATA_IN;
          wr_en_nx = 1'b1;
          timer_nx = '0;
`ifdef WR_ACK_EN
          tx_buf_nx = ALU_OUT_WIDTH'(Addr);
          tx_cnt_nx = CW'(1);
`endif
        end
        RD_ADDR: if (DATA_IN_VALID) begin
          addr_nx  = DATA_IN[ADDR_WIDTH-1:0];
          rd_en_nx = 1'b1;
          timer_nx = '0;
        end
        RD_WAIT: begin
          if (DATA_IN_VALID) cmd_err_nx = 1'b1;
          if (Rd_D_Valid) begin
            tx_buf_nx = ALU_OUT_WIDTH'(Rd_D);
            tx_cnt_nx = CW'(1);
            timer_nx  = '0;
          end
        end
        OPA, OPB: if (DATA_IN_VALID) begin
          addr_nx  = (state == OPA) ? '0 : ADDR_WIDTH'(1);
          wr_d_nx  = DATA_IN;
          wr_en_nx = 1'b1;
          timer_nx = '0;
        end
        ALU_FUN: if (DATA_IN_VALID) begin
          fun_nx     = DATA_IN[FUN_WIDTH-1:0];
          alu_en_nx  = 1'b1;
          gate_en_nx = 1'b1;
          timer_nx   = '0;
        end
        ALU_WAIT: begin
          if (DATA_IN_VALID) cmd_err_nx = 1'b1;
          if (ALU_OUT_Valid) begin
            tx_buf_nx  = ALU_OUT;
            tx_cnt_nx  = CW'(NBYTES);
            gate_en_nx = 1'b0;
            timer_nx   = '0;
          end
        end
        TX_SEND: begin
          if (DATA_IN_VALID) cmd_err_nx = 1'b1;
          // Buffer shifts right so the least significant byte always goes first.
          if (!F_FULL) begin
            w_inc_nx   = 1'b1;
            wr_data_nx = tx_buf[DATA_WIDTH-1:0];
            tx_buf_nx  = tx_buf >> DATA_WIDTH;
            tx_cnt_nx  = tx_cnt - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_sys_ctrl_gen2.sv
// tb/tb_sys_ctrl_gen2.sv - table-driven and randomized self-checking bench for sys_ctrl_gen2
module tb_sys_ctrl_gen2;
  localparam int T = 40;
`ifdef WR_ACK_EN
  localparam int ACK = 1;
`else
  localparam int ACK = 0;
`endif

  logic        CLK = 1'b0, RST = 1'b0;
  logic [7:0]  DATA_IN = '0, Rd_D = '0;
  logic        DATA_IN_VALID = 1'b0, Rd_D_Valid = 1'b0, ALU_OUT_Valid = 1'b0, F_FULL = 1'b0;
  logic [15:0] ALU_OUT = '0;
  logic        WrEn, RdEn, ALU_EN, GATE_EN, W_INC, CMD_ERR;
  logic [3:0]  Addr, FUN;
  logic [7:0]  Wr_D, Wr_DATA;

  always #5 CLK = ~CLK;

  sys_ctrl_gen2 #(.TIMEOUT_CYCLES(T)) dut (
    .CLK(CLK), .RST(RST), .DATA_IN(DATA_IN), .DATA_IN_VALID(DATA_IN_VALID),
    .Rd_D(Rd_D), .Rd_D_Valid(Rd_D_Valid), .ALU_OUT(ALU_OUT), .ALU_OUT_Valid(ALU_OUT_Valid),
    .F_FULL(F_FULL), .WrEn(WrEn), .RdEn(RdEn), .Addr(Addr), .Wr_D(Wr_D), .FUN(FUN),
    .ALU_EN(ALU_EN), .GATE_EN(GATE_EN), .W_INC(W_INC), .Wr_DATA(Wr_DATA), .CMD_ERR(CMD_ERR)
  );

  typedef struct {
    logic [3:0][7:0] f;
    int              nf;
    logic [15:0]     resp;
    int              lat;
    int              full;
    bit              rnd;
    bit              stray;
    int              n_wr;
    logic [1:0][3:0] wa;
    logic [1:0][7:0] wd;
    int              n_rd;
    logic [3:0]      ra;
    int              n_alu;
    logic [3:0]      fun;
    int              n_b;
    logic [1:0][7:0] b;
    int              n_err;
  } vec_t;

  int n_chk = 0, n_pass = 0;
  logic [3:0] log_wa[$], log_ra[$], log_fun[$];
  logic [7:0] log_wd[$], log_b[$];
  int err_n = 0, bp_viol = 0;
  logic ff_q = 1'b0;
  vec_t tbl[8];

  // Event log of DUT output activity, sampled mid-cycle.
  always @(posedge CLK) ff_q <= F_FULL;
  always @(negedge CLK) begin
    if (RST) begin
      if (WrEn) begin log_wa.push_back(Addr); log_wd.push_back(Wr_D); end
      if (RdEn) log_ra.push_back(Addr);
      if (ALU_EN) log_fun.push_back(FUN);
      if (W_INC) begin
        log_b.push_back(Wr_DATA);
        if (ff_q) bp_viol <= bp_viol + 1;
      end
      if (CMD_ERR) err_n <= err_n + 1;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic log_clear();
    log_wa.delete(); log_wd.delete(); log_ra.delete(); log_fun.delete(); log_b.delete();
    err_n = 0;
    bp_viol = 0;
  endtask

  task automatic send(input logic [7:0] f);
    DATA_IN = f;
    DATA_IN_VALID = 1'b1;
    step();
    DATA_IN_VALID = 1'b0;
  endtask

  function automatic vec_t mk(input logic [31:0] f, input int nf, input logic [15:0] resp,
      input int lat, input int full, input int n_wr, input logic [7:0] wa, input logic [15:0] wd,
      input int n_rd, input logic [3:0] ra, input int n_alu, input logic [3:0] fun,
      input int n_b, input logic [15:0] b, input int n_err);
    vec_t v;
    v.f = f; v.nf = nf; v.resp = resp; v.lat = lat; v.full = full; v.rnd = 1'b0; v.stray = 1'b0;
    v.n_wr = n_wr; v.wa = wa; v.wd = wd; v.n_rd = n_rd; v.ra = ra;
    v.n_alu = n_alu; v.fun = fun; v.n_b = n_b; v.b = b; v.n_err = n_err;
    return v;
  endfunction

  // Reference model: expected effects of one command from the command rules alone.
  function automatic vec_t model(input vec_t v);
    vec_t e = v;
    e.n_wr = 0; e.wa = '0; e.wd = '0; e.n_rd = 0; e.ra = '0;
    e.n_alu = 0; e.fun = '0; e.n_b = 0; e.b = '0; e.n_err = v.stray ? 1 : 0;
    case (v.f[0])
      8'hAA: begin
        e.nf = 3; e.n_wr = 1; e.wa[0] = v.f[1][3:0]; e.wd[0] = v.f[2];
        e.n_b = ACK; e.b[0] = {4'h0, v.f[1][3:0]};
      end
      8'hBB: begin
        e.nf = 2; e.n_rd = 1; e.ra = v.f[1][3:0]; e.n_b = 1; e.b[0] = v.resp[7:0];
      end
      8'hCC: begin
        e.nf = 4; e.n_wr = 2; e.wa[0] = 4'd0; e.wd[0] = v.f[1]; e.wa[1] = 4'd1; e.wd[1] = v.f[2];
        e.n_alu = 1; e.fun = v.f[3][3:0]; e.n_b = 2; e.b = v.resp;
      end
      8'hDD: begin
        e.nf = 2; e.n_alu = 1; e.fun = v.f[1][3:0]; e.n_b = 2; e.b = v.resp;
      end
      default: begin
        e.nf = 1; e.n_err = 1;
      end
    endcase
    return e;
  endfunction

  task automatic run_vec(input vec_t v, input string nm);
    int k;
    logic [7:0] held;
    bit hold_bad;
    log_clear();
    held = Wr_DATA;
    for (int i = 0; i < v.nf; i++) begin
      send(v.f[i]);
      if (v.rnd && i < v.nf - 1) repeat ($urandom_range(0, 3)) step();
    end
    if (v.f[0] == 8'hBB || v.f[0] == 8'hCC || v.f[0] == 8'hDD) begin
      k = 0;
      if (v.f[0] == 8'hBB) while (!RdEn && k < 20) begin step(); k++; end
      else while (!ALU_EN && k < 20) begin step(); k++; end
      chk({nm, ".strobe_seen"}, k < 20, 1);
      for (int j = 0; j < v.lat; j++) begin
        if (v.stray && j == 0) begin DATA_IN = 8'($urandom); DATA_IN_VALID = 1'b1; end
        step();
        DATA_IN_VALID = 1'b0;
      end
      if (v.f[0] != 8'hBB) chk({nm, ".gate_on"}, GATE_EN, 1);
      held = Wr_DATA;
      F_FULL = (v.full > 0);
      if (v.f[0] == 8'hBB) begin Rd_D = v.resp[7:0]; Rd_D_Valid = 1'b1; end
      else begin ALU_OUT = v.resp; ALU_OUT_Valid = 1'b1; end
      step();
      Rd_D_Valid = 1'b0;
      ALU_OUT_Valid = 1'b0;
    end
    hold_bad = 1'b0;
    for (int j = 0; j < 14; j++) begin
      if (j < v.full) F_FULL = 1'b1;
      else if (v.rnd && j < 10) F_FULL = ($urandom_range(0, 2) == 0);
      else F_FULL = 1'b0;
      step();
      if (j < v.full && (W_INC || Wr_DATA != held)) hold_bad = 1'b1;
    end
    F_FULL = 1'b0;
    repeat (4) step();
    chk({nm, ".wr_n"}, log_wa.size(), v.n_wr);
    if (log_wa.size() == v.n_wr)
      for (int i = 0; i < v.n_wr; i++) begin
        chk({nm, ".wr_addr"}, log_wa[i], v.wa[i]);
        chk({nm, ".wr_data"}, log_wd[i], v.wd[i]);
      end
    chk({nm, ".rd_n"}, log_ra.size(), v.n_rd);
    if (log_ra.size() == 1 && v.n_rd == 1) chk({nm, ".rd_addr"}, log_ra[0], v.ra);
    chk({nm, ".alu_n"}, log_fun.size(), v.n_alu);
    if (log_fun.size() == 1 && v.n_alu == 1) chk({nm, ".fun"}, log_fun[0], v.fun);
    chk({nm, ".fifo_n"}, log_b.size(), v.n_b);
    if (log_b.size() == v.n_b)
      for (int i = 0; i < v.n_b; i++) chk({nm, ".fifo_byte"}, log_b[i], v.b[i]);
    chk({nm, ".cmd_err"}, err_n, v.n_err);
    chk({nm, ".backpressure"}, bp_viol, 0);
    if (v.full > 0) chk({nm, ".full_hold"}, hold_bad, 0);
    chk({nm, ".gate_off"}, GATE_EN, 0);
  endtask

  initial begin
    int first;
    int k;
    vec_t v;
    tbl[0] = mk(32'h003C05AA, 3, 16'h0000, 0, 0, 1, 8'h05, 16'h003C, 0, 4'h0, 0, 4'h0, ACK, 16'h0005, 0);
    tbl[1] = mk(32'h000002BB, 2, 16'h009E, 3, 0, 0, 8'h00, 16'h0000, 1, 4'h2, 0, 4'h0, 1, 16'h009E, 0);
    tbl[2] = mk(32'h002010CC, 4, 16'h0030, 2, 0, 2, 8'h10, 16'h2010, 0, 4'h0, 1, 4'h0, 2, 16'h0030, 0);
    tbl[3] = mk(32'h002010CC, 4, 16'h0030, 2, 5, 2, 8'h10, 16'h2010, 0, 4'h0, 1, 4'h0, 2, 16'h0030, 0);
    tbl[4] = mk(32'h00000077, 1, 16'h0000, 0, 0, 0, 8'h00, 16'h0000, 0, 4'h0, 0, 4'h0, 0, 16'h0000, 1);
    tbl[5] = mk(32'h000007DD, 2, 16'hA55A, 1, 0, 0, 8'h00, 16'h0000, 0, 4'h0, 1, 4'h7, 2, 16'hA55A, 0);
    tbl[6] = mk(32'h0000F3BB, 2, 16'h0041, 1, 0, 0, 8'h00, 16'h0000, 1, 4'h3, 0, 4'h0, 1, 16'h0041, 0);
    tbl[7] = mk(32'hE98877CC, 4, 16'hBEEF, 4, 2, 2, 8'h10, 16'h8877, 0, 4'h0, 1, 4'h9, 2, 16'hBEEF, 0);

    RST = 1'b0;
    repeat (3) step();
    chk("reset_outputs", {WrEn, RdEn, Addr, Wr_D, FUN, ALU_EN, GATE_EN, W_INC, Wr_DATA, CMD_ERR}, 0);
    RST = 1'b1;
    step();

    for (int i = 0; i < 8; i++) run_vec(tbl[i], $sformatf("vec%0d", i));

    log_clear();
    send(8'hAA);
    first = -1;
    for (int i = 1; i <= 2 * T; i++) begin
      step();
      if (CMD_ERR && first < 0) first = i;
    end
    chk("timeout.err_n", err_n, 1);
    chk("timeout.when", (first >= T - 1) && (first <= T + 1), 1);
    chk("timeout.no_write", log_wa.size(), 0);
    run_vec(tbl[1], "timeout.read_after");

    log_clear();
    send(8'hAA);
    send(8'h05);
    repeat (T - 3) step();
    send(8'h3C);
    repeat (6) step();
    chk("late_frame.wr_n", log_wa.size(), 1);
    if (log_wa.size() == 1) chk("late_frame.wr_data", log_wd[0], 8'h3C);
    chk("late_frame.err_n", err_n, 0);

    log_clear();
    send(8'hCC); send(8'h11); send(8'h22); send(8'h03);
    k = 0;
    while (!ALU_EN && k < 20) begin step(); k++; end
    step();
    chk("rst_mid.gate_on", GATE_EN, 1);
    RST = 1'b0;
    step();
    chk("rst_mid.outputs", {WrEn, RdEn, Addr, Wr_D, FUN, ALU_EN, GATE_EN, W_INC, Wr_DATA, CMD_ERR}, 0);
    RST = 1'b1;
    step();
    log_clear();
    ALU_OUT = 16'h1234;
    ALU_OUT_Valid = 1'b1;
    step();
    ALU_OUT_Valid = 1'b0;
    repeat (8) step();
    chk("rst_mid.no_tx", log_b.size(), 0);
    chk("rst_mid.no_err", err_n, 0);
    run_vec(tbl[1], "rst_mid.read_after");

    for (int r = 0; r < 40; r++) begin
      int sel;
      sel = $urandom_range(0, 4);
      v = mk($urandom, 0, 16'($urandom), $urandom_range(1, 6), 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      case (sel)
        0: v.f[0] = 8'hAA;
        1: v.f[0] = 8'hBB;
        2: v.f[0] = 8'hCC;
        3: v.f[0] = 8'hDD;
        default: do v.f[0] = 8'($urandom); while (v.f[0] inside {8'hAA, 8'hBB, 8'hCC, 8'hDD});
      endcase
      v.rnd = 1'b1;
      if (sel >= 1 && sel <= 3) begin
        v.stray = ($urandom_range(0, 1) == 1);
        v.full = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 5) : 0;
      end
      v = model(v);
      run_vec(v, $sformatf("rnd%0d", r));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/sys_ctrl_gen2.md
Name: sys_ctrl_gen2

Overview:
Parametrised second-generation system controller for the register-file/ALU/UART subsystem. It decodes command frames arriving from the RX data synchroniser, drives register-file writes and reads, and sequences ALU operations, including clock-gate enable. It returns read data and multi-byte ALU results to the TX async FIFO. It adds width generalisation, per-frame timeout recovery, FIFO back-pressure handling and an error pulse.

Parameters:
DATA_WIDTH, 8, frame/register data width.
ADDR_WIDTH, 4, register-file address width.
ALU_OUT_WIDTH, 16, ALU result width; must be an integer multiple of DATA_WIDTH.
FUN_WIDTH, 4, ALU function code width.
TIMEOUT_CYCLES, 1024, idle cycles allowed between frames of one command, or while waiting for a response.

Ports:
CLK  in  1  system clock (REF_CLK domain)
RST  in  1  synchronous active-low reset
DATA_IN  in  DATA_WIDTH  synchronised RX frame
DATA_IN_VALID  in  1  one-cycle strobe for DATA_IN
Rd_D  in  DATA_WIDTH  register-file read data
Rd_D_Valid  in  1  read data valid strobe
ALU_OUT  in  ALU_OUT_WIDTH  ALU result
ALU_OUT_Valid  in  1  ALU result valid strobe
F_FULL  in  1  TX FIFO full
WrEn  out  1  register write enable, one-cycle pulse
RdEn  out  1  register read enable, one-cycle pulse
Addr  out  ADDR_WIDTH  register address
Wr_D  out  DATA_WIDTH  register write data
FUN  out  FUN_WIDTH  ALU function
ALU_EN  out  1  ALU enable, one-cycle pulse
GATE_EN  out  1  ALU clock-gate enable
W_INC  out  1  FIFO write strobe
Wr_DATA  out  DATA_WIDTH  FIFO write data
CMD_ERR  out  1  one-cycle error pulse

Behaviour:
- Clock and reset: one clock, CLK. Reset is synchronous and active-low on RST.
- Reset: all outputs are registered and reset to 0; the FSM resets to IDLE. A reset mid-command abandons the command and any pending FIFO bytes.
- Commands use the low 8 bits of the first frame; upper bits are ignored.
  - 0xAA: register write; frames addr, data.
  - 0xBB: register read; frame addr.
  - 0xCC: ALU op with operands; frames A, B, fun.
  - 0xDD: ALU op without operands; frame fun.
- FSM states: IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT, OPA, OPB, ALU_FUN, ALU_WAIT, TX_SEND.
- IDLE: on a valid frame, go to the state for that command.
  - Any other command code: stay in IDLE and pulse CMD_ERR the next cycle.
- WR_ADDR: latch Addr = DATA_IN[ADDR_WIDTH-1:0] and go to WR_DATA.
- WR_DATA: on a valid frame, Wr_D = DATA_IN and WrEn = 1 for exactly one cycle, on the cycle after the strobe; then go to IDLE.
- RD_ADDR: latch Addr, pulse RdEn for one cycle, go to RD_WAIT.
- RD_WAIT: on Rd_D_Valid, capture Rd_D into the TX buffer (1 byte) and go to TX_SEND.
- OPA: write the frame to address 0, using the same WrEn pulse timing as WR_DATA; go to OPB.
- OPB: write the frame to address 1; go to ALU_FUN.
- ALU_FUN: latch FUN = DATA_IN[FUN_WIDTH-1:0]; on the next cycle assert ALU_EN for one cycle and GATE_EN = 1; go to ALU_WAIT.
- ALU_WAIT: on ALU_OUT_Valid, capture ALU_OUT into the TX buffer (ALU_OUT_WIDTH/DATA_WIDTH bytes), drop GATE_EN the next cycle, go to TX_SEND.
- TX_SEND: emit the buffered bytes, least significant byte first.
  - Each cycle with F_FULL = 0: W_INC = 1 and Wr_DATA = current byte; advance.
  - While F_FULL = 1: W_INC = 0 and Wr_DATA is held.
  - After the last byte, go to IDLE.
- Frames arriving in RD_WAIT, ALU_WAIT or TX_SEND are dropped and CMD_ERR pulses; the state is unchanged.
- Timeout: a counter clears on every accepted frame or response strobe.
  - If it reaches TIMEOUT_CYCLES in any state other than IDLE or TX_SEND: go to IDLE, pulse CMD_ERR, force GATE_EN = 0.
  - TX_SEND never times out.
- A DATA_IN_VALID coincident with the timeout expiry is dropped. Timeout has priority.

Optional Feature:
- Macro WR_ACK_EN.
- When defined: after every 0xAA register write, the controller enters TX_SEND with a 1-byte buffer holding the written address, zero-extended to DATA_WIDTH. The address is pushed to the FIFO with normal back-pressure rules.
- When undefined: register writes produce no FIFO traffic and WR_DATA returns directly to IDLE.

Test Plan:
- Frames 0xAA, 0x05, 0x3C -> one-cycle WrEn with Addr = 5 and Wr_D = 0x3C; no W_INC. With WR_ACK_EN defined, one W_INC with Wr_DATA = 0x05.
- Frames 0xBB, 0x02; Rd_D = 0x9E with Rd_D_Valid 3 cycles after RdEn -> RdEn pulse with Addr = 2, then one W_INC with Wr_DATA = 0x9E.
- Frames 0xCC, 0x10, 0x20, 0x00; ALU_OUT = 0x0030 valid 2 cycles after ALU_EN -> writes to addr 0 and 1, one ALU_EN pulse, GATE_EN high until capture, then FIFO writes 0x30 followed by 0x00.
- Repeat the ALU test with F_FULL held high for 5 cycles during TX_SEND -> W_INC low and Wr_DATA stable throughout; both bytes are still delivered once each, in order.
- Frame 0xAA then no frame for TIMEOUT_CYCLES -> CMD_ERR pulse, return to IDLE; a following 0xBB command executes normally.
- Frame 0x77 -> CMD_ERR pulse, no other output activity. RST low mid-ALU_WAIT -> all outputs 0 on the next edge, FSM in IDLE.
